perf_timer_responder: RTL
=========================

Name: perf_timer_responder

Overview:
- Peripheral-side responder for the CPU's registered peripheral bus, which carries a request strobe, a word address, write data and a write enable.
- Decodes an 8-word register window and returns read data one cycle after each read request.
- Hosts an ID word, a free-running cycle counter, a down-counting timer with auto-reload and interrupt, a scratch register and an error counter.
- Sits directly on the CPU's peripheral outputs; its read data returns to the CPU writeback mux.

Parameters:
- BASE_WORD, 64'h0000_0000_2000_0000: word address of register 0, which is byte address 0x1_0000_0000 >> 3. Must be 8-aligned.
- ID_VALUE, 64'h0000_0533_0001_0000: constant returned by register 0.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- perf_en  in  1  request strobe; each cycle it is high is one access
- perf_addr  in  64  word address of the access
- perf_data  in  64  write data
- perf_wren  in  1  1 = write, 0 = read; valid only while perf_en = 1
- rd_data  out  64  read data; zero when rd_valid = 0
- rd_valid  out  1  one-cycle pulse, one cycle after each read request
- err  out  1  one-cycle pulse, one cycle after any unmapped access
- irq  out  1  level; equals STATUS.expired & CTRL.irq_en, registered

Behaviour:
- Reset (rst = 0, asynchronous): all registers, outputs and counters go to 0. CYCLE restarts at 0 after release.
- Decode: hit when perf_addr[63:3] == BASE_WORD[63:3]; the offset is perf_addr[2:0].
  - Any access with perf_en = 1 and no hit is unmapped: no register changes, err pulses, ERRCNT increments.
  - ERRCNT saturates at 2^ERR_W - 1. An unmapped read still returns rd_valid with rd_data = 0.
- Register map (offset: name, access):
  - 0: ID, RO; writes ignored, no error.
  - 1: CTRL, RW; bit0 = tmr_en, bit1 = irq_en, bit2 = auto_reload; other bits read 0.
  - 2: CYCLE, RW; increments by 1 every cycle and wraps 2^64 - 1 -> 0. A write loads perf_data with no increment that cycle.
  - 3: TIMER, RW, 64-bit.
  - 4: RELOAD, RW, 64-bit.
  - 5: STATUS; bit0 = expired; writing 1 to bit0 clears it.
  - 6: SCRATCH, RW.
  - 7: ERRCNT; reads zero-extended; any write clears it to 0.
- Read timing: a read in cycle N samples the pre-update register value of cycle N. In cycle N+1, rd_valid = 1 and rd_data holds that value.
  - Back-to-back reads give back-to-back rd_valid pulses.
  - Writes never pulse rd_valid.
- Timer, evaluated each cycle while tmr_en = 1:
  - TIMER > 1: decrement by 1.
  - TIMER == 1: set expired. The next value is RELOAD if auto_reload = 1 and RELOAD != 0, otherwise 0.
  - TIMER == 0: hold; expired is not set again.
  - tmr_en = 0: TIMER holds.
- Simultaneous events:
  - A bus write to TIMER overrides the decrement or reload in the same cycle. Expired is still set if the pre-write TIMER was 1 and tmr_en = 1.
  - W1C of STATUS in the same cycle as an expiry: set wins, and expired stays 1.
  - A write to CTRL takes effect the next cycle; the timer step in the write cycle uses the old CTRL.
- irq is registered: it becomes 1 the cycle after expired becomes 1, provided irq_en = 1. Clearing irq_en or expired drops irq one cycle later.
- Reset asserted mid-transaction: a pending rd_valid is cancelled and outputs go to 0 immediately.

Test Plan:
- Reset/ID:
  - Hold rst = 0, then release and read offset 0 -> rd_valid one cycle later with rd_data = 64'h0000_0533_0001_0000.
  - During reset, rd_valid, err and irq = 0.
- Scratch and back-to-back:
  - Write SCRATCH = 64'hDEAD_BEEF_0123_4567.
  - Issue consecutive reads of offsets 6, 1, 6 -> three consecutive rd_valid pulses with DEADBEEF01234567, 0, DEADBEEF01234567.
- One-shot timer:
  - Write TIMER = 3, then CTRL = 3'b011 -> expired set when TIMER steps 1 -> 0, irq = 1 one cycle later, and TIMER reads 0 thereafter.
  - Write STATUS = 1 -> irq = 0 one cycle after the write.
- Auto-reload:
  - Write RELOAD = 5, TIMER = 2, CTRL = 3'b111 -> TIMER sequence 2, 1, 5, 4, 3, 2, 1, 5.
  - expired is set twice; a W1C issued in the same cycle as the second expiry leaves expired = 1.
- Unmapped access:
  - Read word BASE_WORD + 8 -> rd_valid with rd_data = 0, err pulses, ERRCNT reads 1.
  - Preload ERRCNT to 16'hFFFF via 65535 misses -> stays 16'hFFFF. A write to offset 7 clears it to 0.
- CYCLE and reset mid-op:
  - Write CYCLE = 64'hFFFF_FFFF_FFFF_FFFE -> reads return ...FFFF, then 0 (wrap).
  - Assert rst in the cycle after a read request -> rd_valid never pulses.

Source files
------------

// File: rtl/perf_timer_responder.sv
// Peripheral-bus responder: 8-word register window with ID, free-running cycle
// counter, auto-reload down-timer with interrupt, scratch and saturating error count.
module perf_timer_responder #(
   parameter logic [63:0] BASE_WORD = 64'h0000_0000_2000_0000,
   parameter logic [63:0] ID_VALUE  = 64'h0000_0533_0001_0000,
   parameter int unsigned ERR_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        perf_en,
   input  logic [63:0] perf_addr,
   input  logic [63:0] perf_data,
   input  logic        perf_wren,
   output logic [63:0] rd_data,
   output logic        rd_valid,
   output logic        err,
   output logic        irq
);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   logic [2:0]       ctrl_q;
   logic [63:0]      cycle_q;
   logic [63:0]      timer_q;
   logic [63:0]      reload_q;
   logic [63:0]      scratch_q;
   logic             expired_q;
   logic [ERR_W-1:0] errcnt_q;

   logic             hit;
   logic             miss;
   logic             rd_req;
   logic             wr_req;
   logic [2:0]       off;
   logic [63:0]      rd_mux;
   logic [63:0]      timer_d;
   logic             expire_set;
   logic             expired_d;

   assign hit    = (perf_addr[63:3] == BASE_WORD[63:3]);
   assign off    = perf_addr[2:0];
   assign miss   = perf_en & ~hit;
   assign rd_req = perf_en & ~perf_wren;
   assign wr_req = perf_en & perf_wren & hit;

   // Read mux sees pre-update state; unmapped reads return zero.
   always_comb begin
      rd_mux = '0;
      if (hit) begin
         case (off)
            3'd0: rd_mux = ID_VALUE;
            3'd1: rd_mux = {61'd0, ctrl_q};
            3'd2: rd_mux = cycle_q;
            3'd3: rd_mux = timer_q;
            3'd4: rd_mux = reload_q;
            3'd5: rd_mux = {63'd0, expired_q};
            3'd6: rd_mux = scratch_q;
            3'd7: rd_mux = 64'(errcnt_q);
         endcase
      end
   end

   // Timer step uses the current CTRL; a bus write to TIMER overrides the step,
   // and an expiry beats a same-cycle W1C of STATUS.
   always_comb begin
      timer_d    = timer_q;
      expire_set = 1'b0;
      if (ctrl_q[0]) begin
         if (timer_q > 64'd1) begin
            timer_d = timer_q - 64'd1;
         end else if (timer_q == 64'd1) begin
            expire_set = 1'b1;
            timer_d    = (ctrl_q[2] && (reload_q != 64'd0)) ? reload_q : 64'd0;
         end
      end
      if (wr_req && (off == 3'd3)) timer_d = perf_data;

      expired_d = expired_q;
      if (wr_req && (off == 3'd5) && perf_data[0]) expired_d = 1'b0;
      if (expire_set) expired_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q    <= '0;
         cycle_q   <= '0;
         timer_q   <= '0;
         reload_q  <= '0;
         scratch_q <= '0;
         expired_q <= 1'b0;
         errcnt_q  <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         err       <= 1'b0;
         irq       <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         expired_q <= expired_d;
         cycle_q   <= (wr_req && (off == 3'd2)) ? perf_data : cycle_q + 64'd1;
         if (wr_req && (off == 3'd1)) ctrl_q    <= perf_data[2:0];
         if (wr_req && (off == 3'd4)) reload_q  <= perf_data;
         if (wr_req && (off == 3'd6)) scratch_q <= perf_data;
         if (wr_req && (off == 3'd7)) begin
            errcnt_q <= '0;
         end else if (miss && (errcnt_q != ERR_MAX)) begin
            errcnt_q <= errcnt_q + ERR_W'(1);
         end
         rd_valid <= rd_req;
         rd_data  <= rd_req ? rd_mux : 64'd0;
         err      <= miss;
         irq      <= expired_q & ctrl_q[1];
      end
   end

endmodule
